// File: rtl/mem_wb_stage.sv
// Memory stage: issues loads/stores over a valid/ready bus and stalls upstream while an access is
// in flight. It also registers the MEM/WB write-back outputs.
module mem_wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ValidM,
    input  logic            RegWriteM,
    input  logic            ResultSrcM,
    input  logic            MemWriteM,
    input  logic [2:0]      Funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [4:0]      RdM,
    output logic            StallM,
    output logic            MemReqValid,
    input  logic            MemReqReady,
    output logic            MemReqWe,
    output logic [XLEN-1:0] MemReqAddr,
    output logic [XLEN-1:0] MemReqWdata,
    output logic [3:0]      MemReqBe,
    input  logic            MemRspValid,
    input  logic [XLEN-1:0] MemRspRdata,
    output logic            ValidW,
    output logic            RegWriteW,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] ResultW,
    output logic            MisalignW
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t state_q, state_d;

    // Latched copy of the accepted access; the full byte address is kept for load lane selection
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [4:0]      rd_q, rd_d;
    logic            reg_write_q, reg_write_d;

    logic            valid_w_q, valid_w_d;
    logic            reg_write_w_q, reg_write_w_d;
    logic [4:0]      rd_w_q, rd_w_d;
    logic [XLEN-1:0] result_w_q, result_w_d;
    logic            misalign_w_q, misalign_w_d;

    logic            mem_op;
    logic            legal_f3;
    logic            misaligned;
    logic            access_err;
    logic [XLEN-1:0] store_wdata;
    logic [3:0]      store_be;
    logic [7:0]      rsp_byte;
    logic [15:0]     rsp_half;
    logic [XLEN-1:0] load_value;
    logic            stall;

    always_comb begin
        mem_op = ValidM & (MemWriteM | ResultSrcM);
        if (MemWriteM) begin
            legal_f3 = Funct3M inside {3'b000, 3'b001, 3'b010};
        end else begin
            legal_f3 = Funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        case (Funct3M[1:0])
            2'b01:   misaligned = ALUResultM[0];
            2'b10:   misaligned = |ALUResultM[1:0];
            default: misaligned = 1'b0;
        endcase
        access_err = mem_op & (~legal_f3 | misaligned);
    end

    // Stores replicate the data across all lanes so the byte enables alone pick the target bytes
    always_comb begin
        case (Funct3M[1:0])
            2'b00: begin
                store_wdata = {4{WriteDataM[7:0]}};
                store_be    = 4'b0001 << ALUResultM[1:0];
            end
            2'b01: begin
                store_wdata = {2{WriteDataM[15:0]}};
                store_be    = 4'b0011 << {ALUResultM[1], 1'b0};
            end
            default: begin
                store_wdata = WriteDataM;
                store_be    = 4'b1111;
            end
        endcase
        if (!MemWriteM) begin
            store_be = 4'b1111;
        end
    end

    always_comb begin
        case (addr_q[1:0])
            2'b00:   rsp_byte = MemRspRdata[7:0];
            2'b01:   rsp_byte = MemRspRdata[15:8];
            2'b10:   rsp_byte = MemRspRdata[23:16];
            default: rsp_byte = MemRspRdata[31:24];
        endcase
        rsp_half = addr_q[1] ? MemRspRdata[31:16] : MemRspRdata[15:0];
        case (funct3_q)
            3'b000:  load_value = {{(XLEN-8){rsp_byte[7]}}, rsp_byte};
            3'b001:  load_value = {{(XLEN-16){rsp_half[15]}}, rsp_half};
            3'b100:  load_value = {{(XLEN-8){1'b0}}, rsp_byte};
            3'b101:  load_value = {{(XLEN-16){1'b0}}, rsp_half};
            default: load_value = MemRspRdata;
        endcase
    end

    // Cycles that retire nothing leave a bubble in WB so each instruction shows exactly one ValidW pulse
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        we_d          = we_q;
        funct3_d      = funct3_q;
        rd_d          = rd_q;
        reg_write_d   = reg_write_q;
        valid_w_d     = 1'b0;
        reg_write_w_d = 1'b0;
        misalign_w_d  = 1'b0;
        rd_w_d        = rd_w_q;
        result_w_d    = result_w_q;
        stall         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_op && !access_err) begin
                    stall       = 1'b1;
                    addr_d      = ALUResultM;
                    wdata_d     = store_wdata;
                    be_d        = store_be;
                    we_d        = MemWriteM;
                    funct3_d    = Funct3M;
                    rd_d        = RdM;
                    reg_write_d = RegWriteM;
                    state_d     = REQ;
                end else begin
                    valid_w_d     = ValidM;
                    reg_write_w_d = ValidM & RegWriteM & ~access_err;
                    misalign_w_d  = access_err;
                    if (ValidM) begin
                        rd_w_d     = RdM;
                        result_w_d = ALUResultM;
                    end
                end
            end
            REQ: begin
                if (MemReqReady && we_q) begin
                    valid_w_d  = 1'b1;
                    rd_w_d     = rd_q;
                    result_w_d = addr_q;
                    state_d    = IDLE;
                end else begin
                    stall = 1'b1;
                    if (MemReqReady) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (MemRspValid) begin
                    valid_w_d     = 1'b1;
                    reg_write_w_d = reg_write_q;
                    rd_w_d        = rd_q;
                    result_w_d    = load_value;
                    state_d       = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            we_q          <= 1'b0;
            funct3_q      <= '0;
            rd_q          <= '0;
            reg_write_q   <= 1'b0;
            valid_w_q     <= 1'b0;
            reg_write_w_q <= 1'b0;
            rd_w_q        <= '0;
            result_w_q    <= '0;
            misalign_w_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            we_q          <= we_d;
            funct3_q      <= funct3_d;
            rd_q          <= rd_d;
            reg_write_q   <= reg_write_d;
            valid_w_q     <= valid_w_d;
            reg_write_w_q <= reg_write_w_d;
            rd_w_q        <= rd_w_d;
            result_w_q    <= result_w_d;
            misalign_w_q  <= misalign_w_d;
        end
    end

    // Gating with rst keeps the stall low while reset is held even if a memory op sits on the M inputs
    assign StallM      = stall & ~rst;
    assign MemReqValid = (state_q == REQ);
    assign MemReqWe    = we_q;
    assign MemReqAddr  = {addr_q[XLEN-1:2], 2'b00};
    assign MemReqWdata = wdata_q;
    assign MemReqBe    = be_q;

    assign ValidW    = valid_w_q;
    assign RegWriteW = reg_write_w_q;
    assign RdW       = rd_w_q;
    assign ResultW   = result_w_q;
    assign MisalignW = misalign_w_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed and random instructions checked against a memory/extension model,
// with a bus responder that delays ready and response by a chosen number of cycles.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidM, RegWriteM, ResultSrcM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [4:0]  RdM;
    logic        StallM, MemReqValid, MemReqWe;
    logic        MemReqReady = 1'b0;
    logic [31:0] MemReqAddr, MemReqWdata;
    logic [3:0]  MemReqBe;
    logic        MemRspValid = 1'b0;
    logic [31:0] MemRspRdata = 32'h0;
    logic        ValidW, RegWriteW, MisalignW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;

    logic [31:0] mem_model [256];
    int          cur_nr = 0;
    int          cur_d = 0;
    bit          spurious_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    bit          rsp_pending = 1'b0;
    bit          req_active = 1'b0;
    int          rsp_wait = 0;
    int          nr_left = 0;
    logic [31:0] rsp_word = 32'h0;

    mem_wb_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
        .StallM(StallM), .MemReqValid(MemReqValid), .MemReqReady(MemReqReady), .MemReqWe(MemReqWe),
        .MemReqAddr(MemReqAddr), .MemReqWdata(MemReqWdata), .MemReqBe(MemReqBe),
        .MemRspValid(MemRspValid), .MemRspRdata(MemRspRdata),
        .ValidW(ValidW), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .MisalignW(MisalignW)
    );

    always #5 clk = ~clk;

    // Bus responder: holds ready low for cur_nr cycles per request and answers loads cur_d cycles after the handshake
    always @(negedge clk) begin
        #1;
        MemRspValid = 1'b0;
        MemRspRdata = $urandom;
        if (rsp_pending) begin
            if (rsp_wait == 0) begin
                MemRspValid = 1'b1;
                MemRspRdata = rsp_word;
                rsp_pending = 1'b0;
            end else begin
                rsp_wait--;
            end
        end else if (spurious_en && $urandom_range(0, 5) == 0) begin
            MemRspValid = 1'b1;
        end
        if (MemReqValid) begin
            if (!req_active) begin
                req_active = 1'b1;
                nr_left = cur_nr;
            end
            MemReqReady = (nr_left == 0);
            if (nr_left == 0) begin
                req_active = 1'b0;
                if (!MemReqWe) begin
                    rsp_pending = 1'b1;
                    rsp_wait = cur_d;
                    rsp_word = mem_model[MemReqAddr[9:2]];
                end
            end else begin
                nr_left--;
            end
        end else begin
            req_active = 1'b0;
            MemReqReady = 1'($urandom_range(0, 1));
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expectLoad(input logic [31:0] word, input logic [2:0] f3, input int off);
        int unsigned w;
        int v;
        w = word;
        case (f3)
            3'd0, 3'd4: begin
                v = int'((w >> (8 * off)) % 256);
                if (f3 == 3'd0 && v >= 128) v -= 256;
            end
            3'd1, 3'd5: begin
                v = int'((w >> (8 * ((off / 2) * 2))) % 65536);
                if (f3 == 3'd1 && v >= 32768) v -= 65536;
            end
            default: v = int'(w);
        endcase
        return 32'(v);
    endfunction

    // Drives one M instruction at a negedge, holds it while stalled, then checks the WB result and latency
    task automatic applyStimulus(input bit v, input bit st, input bit ld, input logic [2:0] f3,
                                 input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                                 input bit rw, input int nr, input int d);
        bit          mem_op, legal, mis, err, timed_out;
        int          off, size, stalls, valids, exp_stalls;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_load;
        int unsigned idx;

        mem_op = v && (st || ld);
        off = int'(alu % 4);
        size = int'(f3 % 4);
        legal = st ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
        mis = (size == 1 && off % 2 == 1) || (size == 2 && off != 0);
        err = mem_op && (!legal || mis);
        idx = (alu / 4) % 256;
        exp_load = expectLoad(mem_model[idx], f3, off);
        exp_be = 4'hF;
        exp_wd = wd;
        if (st && size == 0) begin
            exp_be = 4'(1 << off);
            exp_wd = (wd % 256) * 32'h0101_0101;
        end else if (st && size == 1) begin
            exp_be = 4'(3 << ((off / 2) * 2));
            exp_wd = (wd % 65536) * 32'h0001_0001;
        end
        if (!mem_op || err) exp_stalls = 0;
        else if (st) exp_stalls = 1 + nr;
        else exp_stalls = 2 + nr + d;

        cur_nr = nr;
        cur_d = d;
        ValidM = v; RegWriteM = rw; ResultSrcM = ld; MemWriteM = st;
        Funct3M = f3; ALUResultM = alu; WriteDataM = wd; RdM = rd;
        stalls = 0; valids = 0; timed_out = 1'b0;
        while (1) begin
            #2;
            if (MemReqValid) begin
                valids++;
                checkOutput("req_addr", MemReqAddr, alu - 32'(off));
                checkOutput("req_we", 32'(MemReqWe), 32'(st));
                checkOutput("req_be", 32'(MemReqBe), 32'(exp_be));
                if (st) checkOutput("req_wdata", MemReqWdata, exp_wd);
            end
            if (!StallM) break;
            stalls++;
            if (stalls > 100) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            checkOutput("wb_no_retire", 32'(ValidW), 32'h0);
        end
        checkOutput("stall_bound", 32'(timed_out), 32'h0);
        @(negedge clk);
        checkOutput("stall_cycles", 32'(stalls), 32'(exp_stalls));
        checkOutput("req_cycles", 32'(valids), (mem_op && !err) ? 32'(nr + 1) : 32'h0);
        checkOutput("wb_valid", 32'(ValidW), 32'(v));
        checkOutput("wb_misalign", 32'(MisalignW), 32'(err));
        checkOutput("wb_regwrite", 32'(RegWriteW), 32'(v && rw && !st && !err));
        if (v && (!mem_op || err)) checkOutput("wb_result_alu", ResultW, alu);
        if (v && !st && !err) checkOutput("wb_rd", 32'(RdW), 32'(rd));
        if (mem_op && ld && !st && !err) checkOutput("wb_result_load", ResultW, exp_load);
        if (mem_op && st && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (exp_be[b]) mem_model[idx][8*b +: 8] = exp_wd[8*b +: 8];
            end
        end
    endtask

    initial begin
        int          kind;
        logic [2:0]  f3;
        logic [31:0] a;

        rst = 1'b1;
        ValidM = 0; RegWriteM = 0; ResultSrcM = 0; MemWriteM = 0;
        Funct3M = 0; ALUResultM = 0; WriteDataM = 0; RdM = 0;
        for (int i = 0; i < 256; i++) mem_model[i] = $urandom;
        mem_model[32'h100 / 4] = 32'h80FF_0000;
        repeat (2) @(negedge clk);
        #2;
        checkOutput("rst_stall", 32'(StallM), 32'h0);
        checkOutput("rst_reqvalid", 32'(MemReqValid), 32'h0);
        checkOutput("rst_validw", 32'(ValidW), 32'h0);
        checkOutput("rst_regwrite", 32'(RegWriteW), 32'h0);
        checkOutput("rst_rd", 32'(RdW), 32'h0);
        checkOutput("rst_result", ResultW, 32'h0);
        checkOutput("rst_misalign", 32'(MisalignW), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed sequence");
        applyStimulus(1, 0, 0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 0);
        applyStimulus(1, 0, 1, 3'b000, 32'h0000_0103, 32'h0, 5'd6, 1, 0, 0);
        applyStimulus(1, 0, 1, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 1, 0, 0);
        applyStimulus(1, 1, 0, 3'b001, 32'h0000_0202, 32'hABCD_1234, 5'd8, 0, 3, 0);
        applyStimulus(1, 0, 1, 3'b010, 32'h0000_0101, 32'h0, 5'd9, 1, 0, 0);
        applyStimulus(1, 0, 1, 3'b011, 32'h0000_0100, 32'h0, 5'd9, 1, 0, 0);
        applyStimulus(0, 0, 0, 3'b000, 32'h0000_0055, 32'h0, 5'd1, 1, 0, 0);
        applyStimulus(1, 0, 1, 3'b010, 32'h0000_0200, 32'h0, 5'd10, 1, 0, 2);
        applyStimulus(1, 0, 0, 3'b000, 32'h0000_0777, 32'h0, 5'd11, 1, 0, 0);

        $display("[TB] reset during WAIT");
        applyStimulus(1, 0, 0, 3'b000, 32'hCAFE_0001, 32'h0, 5'd9, 1, 0, 0);
        cur_nr = 0;
        cur_d = 6;
        ValidM = 1; RegWriteM = 1; ResultSrcM = 1; MemWriteM = 0;
        Funct3M = 3'b010; ALUResultM = 32'h0000_0040; RdM = 5'd7;
        @(negedge clk);
        @(negedge clk);
        #2;
        checkOutput("wait_stall", 32'(StallM), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("arst_stall", 32'(StallM), 32'h0);
        checkOutput("arst_reqvalid", 32'(MemReqValid), 32'h0);
        checkOutput("arst_validw", 32'(ValidW), 32'h0);
        checkOutput("arst_regwrite", 32'(RegWriteW), 32'h0);
        checkOutput("arst_rd", 32'(RdW), 32'h0);
        checkOutput("arst_result", ResultW, 32'h0);
        checkOutput("arst_misalign", 32'(MisalignW), 32'h0);
        ValidM = 0; ResultSrcM = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            #2;
            checkOutput("late_rsp_validw", 32'(ValidW), 32'h0);
            checkOutput("late_rsp_stall", 32'(StallM), 32'h0);
        end
        @(negedge clk);
        applyStimulus(1, 0, 1, 3'b000, 32'h0000_0103, 32'h0, 5'd3, 1, 1, 1);

        $display("[TB] random sequence");
        spurious_en = 1'b1;
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            f3 = 3'($urandom_range(0, 7));
            a = $urandom_range(0, 1023);
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
            if (kind == 0) begin
                applyStimulus(0, 0, 0, f3, $urandom, $urandom, 5'($urandom), 1'($urandom), 0, 0);
            end else if (kind <= 3) begin
                applyStimulus(1, 0, 0, f3, $urandom, $urandom, 5'($urandom), 1'($urandom), 0, 0);
            end else if (kind <= 6) begin
                applyStimulus(1, 0, 1, f3, a, $urandom, 5'($urandom), 1'($urandom),
                              $urandom_range(0, 2), $urandom_range(0, 2));
            end else begin
                applyStimulus(1, 1, 0, f3, a, $urandom, 5'($urandom), 1'($urandom),
                              $urandom_range(0, 2), 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-stage consumer of the EX/MEM pipeline register; sits between that register and the register-file write-back.
- Accepts one M-stage instruction per cycle.
- Performs loads and stores over a valid/ready data-memory bus, with byte/half/word lanes and sign/zero extension.
- Stalls the upstream pipeline while a memory access is outstanding; produces registered MEM/WB outputs.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- ValidM  in  1  an M-stage instruction is present.
- RegWriteM  in  1  instruction writes rd.
- ResultSrcM  in  1  0 = ALU result, 1 = load.
- MemWriteM  in  1  store.
- Funct3M  in  3  access size/sign.
- ALUResultM  in  32  address for memory ops, else result.
- WriteDataM  in  32  store data.
- RdM  in  5  destination register.
- StallM  out  1  hold EX/MEM register and everything upstream.
- MemReqValid  out  1  bus request valid.
- MemReqReady  in  1  bus accepts request.
- MemReqWe  out  1  1 = write.
- MemReqAddr  out  32  word-aligned address ({addr[31:2],2'b00}).
- MemReqWdata  out  32  lane-replicated store data.
- MemReqBe  out  4  byte enables.
- MemRspValid  in  1  read data valid (loads only).
- MemRspRdata  in  32  read word.
- ValidW  out  1  WB slot holds an instruction.
- RegWriteW  out  1  write rd this cycle.
- RdW  out  5  destination register.
- ResultW  out  32  write-back value.
- MisalignW  out  1  access was misaligned or illegal; no bus access made.

Behaviour:
- Memory op = ValidM & (MemWriteM | ResultSrcM).
- Legal Funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Error = memory op with illegal Funct3, or H with addr[0]=1, or W with addr[1:0]!=0.
- FSM states: IDLE, REQ, WAIT. Reset -> IDLE.
- IDLE:
  - Memory op without error -> StallM=1 (combinational), latch address/data/size/rd/RegWrite, next REQ.
  - Otherwise -> StallM=0; WB registers load the M instruction at the next edge; remain IDLE.
- REQ:
  - MemReqValid=1; address/we/be/wdata are held stable from the latched copy until MemReqReady.
  - Handshake on a store -> StallM=0 that cycle; WB loads a bubble-with-valid (ValidW=1, RegWriteW=0); next IDLE.
  - Handshake on a load -> next WAIT; StallM=1.
- WAIT:
  - StallM = !MemRspValid.
  - On MemRspValid: select lane by addr[1:0] (byte) or addr[1] (half); sign-extend for LB/LH, zero-extend for LBU/LHU.
  - ResultW <= extended data; RegWriteW <= latched RegWrite; next IDLE.
  - MemRspValid outside WAIT is ignored.
- Store encoding:
  - SB: MemReqWdata = {4{data[7:0]}}, MemReqBe = 0001 << addr[1:0].
  - SH: MemReqWdata = {2{data[15:0]}}, MemReqBe = 0011 << {addr[1],0}.
  - SW: full word, MemReqBe = 1111.
  - Loads: MemReqWe=0, MemReqBe=1111.
- Error case: handled in IDLE in one cycle, no bus request. WB gets ValidW=1, RegWriteW=0, MisalignW=1, ResultW=ALUResultM.
- Non-memory op: ResultW=ALUResultM, RegWriteW=RegWriteM, ValidW=1.
- !ValidM in IDLE: ValidW=0, RegWriteW=0, MisalignW=0 (bubble).
- WB outputs are registered, with exactly one update per retired M instruction. Minimum latency:
  - ALU op: 1 cycle.
  - Store: 2 cycles.
  - Load: 3 cycles. Each cycle of MemReqReady=0 or MemRspValid=0 adds one.
- MemReqValid is never dropped before the handshake.
- rst mid-operation: immediate return to IDLE. MemReqValid, StallM and all WB outputs go to 0; the in-flight access is abandoned.
- Reset values: ValidW=0, RegWriteW=0, RdW=0, ResultW=0, MisalignW=0, MemReqValid=0, StallM=0.

Test Plan:
- ALU op (ValidM=1, RegWriteM=1, ResultSrcM=0, ALUResultM=0x1234, RdM=5) -> next cycle ValidW=1, RegWriteW=1, RdW=5, ResultW=0x1234; StallM never asserted.
- LB at addr 0x103, MemReqReady=1 immediately, rsp 1 cycle later with rdata=0x80FF_0000 -> MemReqAddr=0x100, StallM high 2 cycles, ResultW=0xFFFFFF80. LBU on the same data -> 0x00000080.
- SH at 0x202, data 0xABCD1234, MemReqReady low 3 cycles -> MemReqValid held 4 cycles with stable fields, MemReqBe=1100, MemReqWdata=0x12341234; WB ValidW=1, RegWriteW=0.
- LW at 0x101 -> no MemReqValid; next cycle MisalignW=1, RegWriteW=0, StallM=0. Funct3=011 load -> same.
- Back-to-back LW (rsp after 2 wait cycles) then ADD -> ADD is not retired until the load completes; WB order load then ADD; no dropped or duplicated ValidW.
- rst asserted during WAIT -> outputs 0 asynchronously. A late MemRspValid after reset is ignored; the next instruction proceeds normally.
